id_decode_queue: RTL and testbench
==================================

// Module: id_decode_queue
// PURPOSE
//  Parametrised decode stage with an instruction queue between fetch and execute.
//  Each instruction is decoded into a 17-bit control bundle when it is enqueued.
//  The bundle is stored with the instruction and PC in a DEPTH-entry FIFO and issued under valid/ready.
//  Serialising instructions (break, syscall, reserved, eret) block further enqueue until they issue.
// PARAMETERS
//  DEPTH  4   queue entries; power of two, >=2
//  PC_W   32  width of the PC tag carried with each instruction
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     fetch offers in_inst/in_pc
//  in_ready   out  1     queue accepts this cycle
//  in_inst    in   32    instruction word
//  in_pc      in   PC_W  PC of in_inst
//  flush      in   1     discard all entries (exception/redirect)
//  out_valid  out  1     head entry valid
//  out_ready  in   1     execute consumes head
//  out_inst   out  32    head instruction
//  out_pc     out  PC_W  head PC
//  out_ctrl   out  17    head bundle {regwrite,regdst,alusrc,branch,memen,memtoreg,jump,jal,jr,bal,
//                        hilowrite,brk,syscall,ri,eret,mtc0,mfc0} ([16]..[0])
//  count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (async):
//   - count=0; pointers=0; state=RUN; out_valid=0; out_ctrl=0; out_inst=0; out_pc=0
//   - in_ready=0 while rst is high
//  Enqueue/issue:
//   - Enqueue on in_valid&in_ready; in_ready = !rst & state==RUN & count<DEPTH
//   - Issue on out_valid&out_ready; out_valid = count!=0
//   - out_* show the head entry combinationally; out_ctrl=0 when empty
//   - Latency 1 cycle: an entry enqueued at edge N is visible after edge N; no same-cycle bypass
//   - Full: in_ready=0 even if the head issues this cycle
//   - Enqueue and issue in the same cycle: count unchanged
//   - Pointers wrap modulo DEPTH
//  flush (sync, highest priority):
//   - Next edge: count=0, pointers=0, state=RUN
//   - An enqueue or issue in the flush cycle is discarded, and the issue does not count as consumed
//  Decode by op (names = bundle bits set; unmatched op -> ri):
//   - op 000000, by funct:
//       MFHI 010000, MFLO 010010 -> regwrite,regdst,hilowrite
//       MTHI 010001, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 -> hilowrite
//       JR 001000 -> jr;  JALR 001001 -> regwrite,regdst,jr
//       BREAK 001101 -> brk;  SYSCALL 001100 -> syscall;  other funct -> regwrite,regdst
//   - ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU -> regwrite,alusrc
//   - BEQ/BNE/BGTZ/BLEZ -> branch
//   - op 000001, by rt:
//       BLTZ 00000, BGEZ 00001 -> branch
//       BLTZAL 10000, BGEZAL 10001 -> regwrite,branch,bal;  other rt -> all zero
//   - J -> jump;  JAL -> regwrite,jal
//   - LB/LBU/LH/LHU/LW -> regwrite,alusrc,memen,memtoreg;  SB/SH/SW -> alusrc,memen
//  Serialise FSM:
//   - RUN->HOLD when the enqueued bundle has any of brk,syscall,ri,eret
//   - HOLD->RUN when that entry issues (count reaches 0 with no enqueue) or on flush
//   - HOLD forces in_ready=0
// CONFIGURATION
//  DECQ_COP0_EN defined: op 010000 decoded as
//   - inst==32'h42000018 -> eret (serialising)
//   - rs==00100 -> mtc0
//   - rs==00000 -> regwrite,mfc0
//   - otherwise -> ri
//  DECQ_COP0_EN undefined: op 010000 -> ri; eret/mtc0/mfc0 bits tied 0
// TESTING
//  T1 reset mid-stream with 3 entries -> count=0, out_valid=0, out_ctrl=0 at once; in_ready=1 after rst falls
//  T2 enqueue ADDIU 0x24420001, out_ready=0 -> next cycle out_valid=1, out_ctrl=17'h14000, count=1
//  T3 out_ready=0, 4 enqueues (DEPTH=4) -> in_ready=0, count=4
//     -> then in_valid=1 and out_ready=1 for one cycle: count=3, no enqueue
//  T4 enqueue SYSCALL 0x0000000C -> in_ready=0 while queued
//     -> after it issues, in_ready=1; out_ctrl was 17'h00010
//  T5 flush with in_valid=1 and 2 entries -> count=0 next cycle; in_pc not stored
//  T6 with DECQ_COP0_EN: 0x40026000 -> out_ctrl 17'h10001;  without it: 17'h00008

Source files
------------

// File: rtl/id_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_queue
// Purpose  : Decode stage with a DEPTH-entry instruction queue between fetch
//            and execute; serialising instructions stall enqueue until issued.
//            Optional COP0 decode (eret/mtc0/mfc0) enabled by DECQ_COP0_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [16:0]                out_ctrl,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam int c_B_REGWRITE = 16;
    localparam int c_B_REGDST   = 15;
    localparam int c_B_ALUSRC   = 14;
    localparam int c_B_BRANCH   = 13;
    localparam int c_B_MEMEN    = 12;
    localparam int c_B_MEMTOREG = 11;
    localparam int c_B_JUMP     = 10;
    localparam int c_B_JAL      = 9;
    localparam int c_B_JR       = 8;
    localparam int c_B_BAL      = 7;
    localparam int c_B_HILO     = 6;
    localparam int c_B_BRK      = 5;
    localparam int c_B_SYSCALL  = 4;
    localparam int c_B_RI       = 3;
    localparam int c_B_ERET     = 2;
    localparam int c_B_MTC0     = 1;
    localparam int c_B_MFC0     = 0;

    // brk, syscall, ri and eret all stall the front end until they issue
    localparam logic [16:0] c_SERIAL_MASK = 17'h0003C;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_ADDR_W-1:0]    r_wr_ptr;
    logic [c_ADDR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic [31:0]            r_inst_mem [DEPTH];
    logic [PC_W-1:0]        r_pc_mem   [DEPTH];
    logic [16:0]            r_ctrl_mem [DEPTH];

    logic [5:0]             w_op;
    logic [5:0]             w_funct;
    logic [4:0]             w_rt;
    logic [16:0]            w_dec;
    logic                   w_empty;
    logic                   w_enq;
    logic                   w_iss;

    assign w_op    = in_inst[31:26];
    assign w_funct = in_inst[5:0];
    assign w_rt    = in_inst[20:16];

`ifdef DECQ_COP0_EN
    logic [4:0] w_rs;
    assign w_rs = in_inst[25:21];
`endif

    // ------------------------------------------------------------------
    // Instruction decode (applied to the word being enqueued)
    // ------------------------------------------------------------------
    always_comb begin
        w_dec = '0;
        case (w_op)
            6'b000000: begin
                case (w_funct)
                    6'b010000, 6'b010010: begin
                        w_dec[c_B_REGWRITE] = 1'b1;
                        w_dec[c_B_REGDST]   = 1'b1;
                        w_dec[c_B_HILO]     = 1'b1;
                    end
                    6'b010001, 6'b010011, 6'b011000,
                    6'b011001, 6'b011010, 6'b011011: w_dec[c_B_HILO] = 1'b1;
                    6'b001000: w_dec[c_B_JR] = 1'b1;
                    6'b001001: begin
                        w_dec[c_B_REGWRITE] = 1'b1;
                        w_dec[c_B_REGDST]   = 1'b1;
                        w_dec[c_B_JR]       = 1'b1;
                    end
                    6'b001101: w_dec[c_B_BRK]     = 1'b1;
                    6'b001100: w_dec[c_B_SYSCALL] = 1'b1;
                    default: begin
                        w_dec[c_B_REGWRITE] = 1'b1;
                        w_dec[c_B_REGDST]   = 1'b1;
                    end
                endcase
            end
            6'b001100, 6'b001101, 6'b001110, 6'b001111,
            6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
                w_dec[c_B_REGWRITE] = 1'b1;
                w_dec[c_B_ALUSRC]   = 1'b1;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: w_dec[c_B_BRANCH] = 1'b1;
            6'b000001: begin
                case (w_rt)
                    5'b00000, 5'b00001: w_dec[c_B_BRANCH] = 1'b1;
                    5'b10000, 5'b10001: begin
                        w_dec[c_B_REGWRITE] = 1'b1;
                        w_dec[c_B_BRANCH]   = 1'b1;
                        w_dec[c_B_BAL]      = 1'b1;
                    end
                    default: w_dec = '0;
                endcase
            end
            6'b000010: w_dec[c_B_JUMP] = 1'b1;
            6'b000011: begin
                w_dec[c_B_REGWRITE] = 1'b1;
                w_dec[c_B_JAL]      = 1'b1;
            end
            6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011: begin
                w_dec[c_B_REGWRITE] = 1'b1;
                w_dec[c_B_ALUSRC]   = 1'b1;
                w_dec[c_B_MEMEN]    = 1'b1;
                w_dec[c_B_MEMTOREG] = 1'b1;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                w_dec[c_B_ALUSRC] = 1'b1;
                w_dec[c_B_MEMEN]  = 1'b1;
            end
`ifdef DECQ_COP0_EN
            6'b010000: begin
                if (in_inst == 32'h42000018) begin
                    w_dec[c_B_ERET] = 1'b1;
                end else if (w_rs == 5'b00100) begin
                    w_dec[c_B_MTC0] = 1'b1;
                end else if (w_rs == 5'b00000) begin
                    w_dec[c_B_REGWRITE] = 1'b1;
                    w_dec[c_B_MFC0]     = 1'b1;
                end else begin
                    w_dec[c_B_RI] = 1'b1;
                end
            end
`else
            6'b010000: w_dec[c_B_RI] = 1'b1;
`endif
            default: w_dec[c_B_RI] = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_empty   = (r_count == '0);
    assign out_valid = !w_empty;
    assign in_ready  = !rst && (r_state == ST_RUN) && (r_count < c_FULL);
    assign w_enq     = in_valid && in_ready;
    assign w_iss     = out_valid && out_ready;

    assign out_inst  = w_empty ? '0 : r_inst_mem[r_rd_ptr];
    assign out_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign out_ctrl  = w_empty ? '0 : r_ctrl_mem[r_rd_ptr];
    assign count     = r_count;

    // Payload storage needs no reset; empty-gating hides stale contents
    always_ff @(posedge clk) begin
        if (w_enq && !flush) begin
            r_inst_mem[r_wr_ptr] <= in_inst;
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_ctrl_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_iss) r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            case ({w_enq, w_iss})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // HOLD implies nothing was enqueued behind the serialising entry,
    // so it has issued exactly when the last occupied slot drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (flush) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_enq && |(w_dec & c_SERIAL_MASK)) r_state <= ST_HOLD;
                ST_HOLD: if (w_iss && (r_count == c_ONE)) r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_decode_queue.sv
`default_nettype none
// Bench for id_decode_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model with a table-driven decoder.
module tb_id_decode_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [16:0] RW = 17'h10000, RD = 17'h08000, AS = 17'h04000, BR = 17'h02000;
    localparam logic [16:0] ME = 17'h01000, MR = 17'h00800, JP = 17'h00400, JL = 17'h00200;
    localparam logic [16:0] JR = 17'h00100, BL = 17'h00080, HL = 17'h00040, BK = 17'h00020;
    localparam logic [16:0] SC = 17'h00010, RI = 17'h00008, ER = 17'h00004, MT = 17'h00002;
    localparam logic [16:0] MF = 17'h00001;
    localparam logic [16:0] SERIAL = BK | SC | RI | ER;

    localparam logic [31:0] M_OP = 32'hFC000000, M_FN = 32'hFC00003F;
    localparam logic [31:0] M_RT = 32'hFC1F0000, M_RS = 32'hFFE00000, M_ALL = 32'hFFFFFFFF;

    logic            clk = 1'b0, rst = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0]     in_inst = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            in_ready, out_valid;
    logic [31:0]     out_inst;
    logic [PC_W-1:0] out_pc;
    logic [16:0]     out_ctrl;
    logic [CW-1:0]   count;

    id_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- decode table (first match wins) ----------------
    logic [31:0] t_mask [64];
    logic [31:0] t_val  [64];
    logic [16:0] t_ctrl [64];
    int          t_n = 0;

    function automatic void add(input logic [31:0] m, input logic [31:0] v, input logic [16:0] c);
        t_mask[t_n] = m; t_val[t_n] = v; t_ctrl[t_n] = c; t_n++;
    endfunction
    function automatic logic [31:0] opv(input logic [5:0] o);   return {o, 26'b0};                  endfunction
    function automatic logic [31:0] fnv(input logic [5:0] f);   return {26'b0, f};                  endfunction
    function automatic logic [31:0] rtv(input logic [4:0] r);   return {6'b000001, 5'b0, r, 16'b0}; endfunction
    function automatic logic [31:0] rsv(input logic [4:0] r);   return {6'b010000, r, 21'b0};       endfunction

    task automatic build_table();
        add(M_FN, fnv(6'h10), RW|RD|HL); add(M_FN, fnv(6'h12), RW|RD|HL);
        add(M_FN, fnv(6'h11), HL); add(M_FN, fnv(6'h13), HL); add(M_FN, fnv(6'h18), HL);
        add(M_FN, fnv(6'h19), HL); add(M_FN, fnv(6'h1A), HL); add(M_FN, fnv(6'h1B), HL);
        add(M_FN, fnv(6'h08), JR); add(M_FN, fnv(6'h09), RW|RD|JR);
        add(M_FN, fnv(6'h0D), BK); add(M_FN, fnv(6'h0C), SC);
        add(M_OP, opv(6'h00), RW|RD);
        for (int o = 8; o < 16; o++) add(M_OP, opv(6'(o)), RW|AS);
        for (int o = 4; o < 8; o++)  add(M_OP, opv(6'(o)), BR);
        add(M_RT, rtv(5'h00), BR); add(M_RT, rtv(5'h01), BR);
        add(M_RT, rtv(5'h10), RW|BR|BL); add(M_RT, rtv(5'h11), RW|BR|BL);
        add(M_OP, opv(6'h01), 17'h0);
        add(M_OP, opv(6'h02), JP); add(M_OP, opv(6'h03), RW|JL);
        add(M_OP, opv(6'h20), RW|AS|ME|MR); add(M_OP, opv(6'h21), RW|AS|ME|MR);
        add(M_OP, opv(6'h23), RW|AS|ME|MR); add(M_OP, opv(6'h24), RW|AS|ME|MR);
        add(M_OP, opv(6'h25), RW|AS|ME|MR);
        add(M_OP, opv(6'h28), AS|ME); add(M_OP, opv(6'h29), AS|ME); add(M_OP, opv(6'h2B), AS|ME);
`ifdef DECQ_COP0_EN
        add(M_ALL, 32'h42000018, ER);
        add(M_RS, rsv(5'b00100), MT);
        add(M_RS, rsv(5'b00000), RW|MF);
`endif
        add(M_OP, opv(6'h10), RI);
    endtask

    function automatic logic [16:0] model_dec(input logic [31:0] i);
        for (int k = 0; k < t_n; k++)
            if ((i & t_mask[k]) == t_val[k]) return t_ctrl[k];
        return RI;
    endfunction

    // ---------------- queue model ----------------
    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [16:0]     ctrl;
    } ent_t;
    ent_t mq[$];

    // Enqueue is blocked while any serialising entry sits in the queue
    function automatic bit blocked();
        foreach (mq[k]) if ((mq[k].ctrl & SERIAL) != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit enq, iss;
        ent_t e;
        if (rst) begin
            mq.delete();
        end else begin
            enq = in_valid && (mq.size() < DEPTH) && !blocked();
            iss = out_ready && (mq.size() != 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (iss) void'(mq.pop_front());
                if (enq) begin
                    e.inst = in_inst; e.pc = in_pc; e.ctrl = model_dec(in_inst);
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit rdy;
        if (cmp_en) begin
            rdy = !rst && (mq.size() < DEPTH) && !blocked();
            chk("in_ready", 64'(in_ready), 64'(rdy));
            chk("count", 64'(count), 64'(mq.size()));
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("out_ctrl", 64'(out_ctrl), 64'(mq.size() != 0 ? mq[0].ctrl : 17'h0));
            if (mq.size() != 0) begin
                chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
                chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        int s = $urandom_range(0, 19);
        logic [5:0] iops [21] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                  6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h20, 6'h21,
                                  6'h23, 6'h24, 6'h25, 6'h28, 6'h2B};
        logic [5:0] fns [14] = '{6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h08, 6'h09, 6'h0D, 6'h0C, 6'h20, 6'h21};
        logic [4:0] rts [5]  = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h05};
        logic [4:0] rss [4]  = '{5'h00, 5'h04, 5'h10, 5'h0B};
        if (s < 10) r[31:26] = iops[$urandom_range(0, 20)];
        else if (s < 14) begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 13)]; end
        else if (s < 16) begin r[31:26] = 6'h01; r[20:16] = rts[$urandom_range(0, 4)]; end
        else if (s < 18) begin
            r[31:26] = 6'h10; r[25:21] = rss[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) r = 32'h42000018;
        end
        return r;
    endfunction

    initial begin
        build_table();
        // model pins
        chk("pin_addiu", 64'(model_dec(32'h24420001)), 64'h14000);
        chk("pin_syscall", 64'(model_dec(32'h0000000C)), 64'h00010);
        chk("pin_lw", 64'(model_dec(32'h8C820004)), 64'h15800);
        chk("pin_bgezal", 64'(model_dec(32'h04110003)), 64'h12080);
`ifdef DECQ_COP0_EN
        chk("pin_mfc0", 64'(model_dec(32'h40026000)), 64'h10001);
`else
        chk("pin_mfc0", 64'(model_dec(32'h40026000)), 64'h00008);
`endif

        #1 rst = 1'b1;
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        rst = 1'b0;
        #1 chk("rst_release_in_ready", 64'(in_ready), 64'h1);

        // T2 enqueue ADDIU, visible only after the edge
        tick();
        in_valid = 1'b1; in_inst = 32'h24420001; in_pc = 32'h100;
        #1 chk("t2_no_bypass", 64'(out_valid), 64'h0);
        tick();
        in_valid = 1'b0;
        chk("t2_out_valid", 64'(out_valid), 64'h1);
        chk("t2_out_ctrl", 64'(out_ctrl), 64'h14000);
        chk("t2_count", 64'(count), 64'h1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // T3 fill then try enqueue + issue when full
        in_valid = 1'b1; in_inst = 32'h24420001;
        for (int k = 0; k < DEPTH; k++) begin in_pc = 32'h300 + k; tick(); end
        chk("t3_in_ready_full", 64'(in_ready), 64'h0);
        chk("t3_count_full", 64'(count), 64'(DEPTH));
        in_pc = 32'hDEAD; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        chk("t3_count_after", 64'(count), 64'(DEPTH - 1));
        chk("t3_head_pc", 64'(out_pc), 64'h301);
        repeat (DEPTH - 1) tick();
        out_ready = 1'b0;
        chk("t3_drained", 64'(count), 64'h0);

        // T4 SYSCALL serialises
        in_valid = 1'b1; in_inst = 32'h0000000C; in_pc = 32'h400; tick();
        chk("t4_ctrl", 64'(out_ctrl), 64'h00010);
        chk("t4_in_ready_hold", 64'(in_ready), 64'h0);
        in_inst = 32'h24420001; in_pc = 32'h404; tick();
        chk("t4_count_hold", 64'(count), 64'h1);
        out_ready = 1'b1; tick();
        chk("t4_count_issued", 64'(count), 64'h0);
        chk("t4_in_ready_back", 64'(in_ready), 64'h1);
        out_ready = 1'b0; tick();
        in_valid = 1'b0;
        chk("t4_post_enq", 64'(out_pc), 64'h404);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // T5 flush discards entries and the concurrent enqueue/issue
        in_valid = 1'b1; in_inst = 32'h24420001;
        in_pc = 32'h500; tick(); in_pc = 32'h504; tick();
        chk("t5_count_pre", 64'(count), 64'h2);
        flush = 1'b1; in_pc = 32'h555; out_ready = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_count_flush", 64'(count), 64'h0);
        chk("t5_out_valid", 64'(out_valid), 64'h0);
        tick();
        chk("t5_count_after", 64'(count), 64'h0);

        // T6 COP0 decode
        in_valid = 1'b1; in_inst = 32'h40026000; in_pc = 32'h600; tick();
        in_valid = 1'b0;
`ifdef DECQ_COP0_EN
        chk("t6_ctrl", 64'(out_ctrl), 64'h10001);
`else
        chk("t6_ctrl", 64'(out_ctrl), 64'h00008);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // T1 async reset mid-stream with three entries
        in_valid = 1'b1; in_inst = 32'h24420001;
        for (int k = 0; k < 3; k++) begin in_pc = 32'h700 + k; tick(); end
        in_valid = 1'b0;
        chk("t1_count_pre", 64'(count), 64'h3);
        rst = 1'b1;
        #1;
        chk("t1_count", 64'(count), 64'h0);
        chk("t1_out_valid", 64'(out_valid), 64'h0);
        chk("t1_out_ctrl", 64'(out_ctrl), 64'h0);
        chk("t1_in_ready", 64'(in_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1 chk("t1_in_ready_after", 64'(in_ready), 64'h1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 31) == 0);
        end
        tick();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("final_drained", 64'(count), 64'h0);
        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
